// File: rtl/cmos_cap_pkg.sv
// Shared definitions for the OV5640 DVP capture front-end.
//   cap_state_t   : capture FSM encoding (SKIP / IDLE / ACTIVE)
//   H_ACT_DEF     : default active pixels per line
//   V_ACT_DEF     : default active lines per frame
//   CNT_W         : width of the pixel and line counters
//   FRAME_CNT_W   : width of the captured-frame counter
//   SKIP_CNT_W    : width of the settling-frame counter
//   pack_rgb565() : builds the output word from the two sensor bytes
package cmos_cap_pkg;

    typedef enum logic [1:0] {
        SKIP   = 2'd0,
        IDLE   = 2'd1,
        ACTIVE = 2'd2
    } cap_state_t;

    localparam int H_ACT_DEF   = 1024;
    localparam int V_ACT_DEF   = 768;
    localparam int CNT_W       = 11;
    localparam int FRAME_CNT_W = 8;
    localparam int SKIP_CNT_W  = 8;

    // hi = first byte of the pixel (R5 G3), lo = second byte (G3 B5).
    // With swap set, the red and blue fields trade places.
    function automatic logic [15:0] pack_rgb565(input logic [7:0] hi,
                                                input logic [7:0] lo,
                                                input logic       swap);
        logic [15:0] word;
        if (swap) begin
            word = {lo[4:0], hi[2:0], lo[7:5], hi[7:3]};
        end else begin
            word = {hi, lo};
        end
        return word;
    endfunction

endpackage

// File: rtl/cmos_frame_capture_byte_pair.sv
// Pairs consecutive 8-bit sensor bytes into one RGB565 pixel.
// Ports:
//   cmos_pclk, rst_n : pixel clock, async active-low reset
//   en               : pairing allowed (capture FSM is ACTIVE)
//   hr_q, db_q       : registered line-valid and data byte
//   de               : one-cycle pulse when a pixel completes
//   data             : completed pixel, held between pulses
//   phase            : 1 while the high byte of a pixel is stored
module cmos_byte_pair
    import cmos_cap_pkg::*;
#(
    parameter bit SWAP_RB = 1'b1
) (
    input  logic        cmos_pclk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        hr_q,
    input  logic [7:0]  db_q,
    output logic        de,
    output logic [15:0] data,
    output logic        phase
);

    logic [7:0] hi;

    always_ff @(posedge cmos_pclk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= 1'b0;
            hi    <= '0;
            de    <= 1'b0;
            data  <= '0;
        end else begin
            de <= 1'b0;
            if (en && hr_q) begin
                phase <= ~phase;
                if (!phase) begin
                    hi <= db_q;
                end else begin
                    de   <= 1'b1;
                    data <= pack_rgb565(hi, db_q, SWAP_RB);
                end
            end else if (!hr_q) begin
                // Every line starts on a high byte, even after an odd-length line.
                phase <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cmos_frame_capture.sv
// OV5640 DVP capture front-end feeding the frame buffer's video input.
// Discards the sensor's settling frames after reset, pairs bytes into
// RGB565 pixels and checks every captured frame's geometry.
// Ports:
//   cmos_pclk, rst_n       : sensor pixel clock, async active-low reset
//   cmos_vsync/href/db     : raw DVP pins
//   cap_en                 : capture enable, honoured at frame boundaries
//   err_clr                : clears the sticky error
//   vout_vs_n/de/data      : frame-buffer video input (vsync active low)
//   frame_cnt              : captured frames, wraps
//   err                    : sticky line-length / line-count error
//   cap_active             : FSM is in ACTIVE
//
// state  | meaning
// SKIP   | after reset, dropping SKIP_FRAMES settling frames
// IDLE   | capture disabled, waiting for cap_en at a frame start
// ACTIVE | capturing and checking pixels
module cmos_frame_capture
    import cmos_cap_pkg::*;
#(
    parameter int H_ACT       = H_ACT_DEF,
    parameter int V_ACT       = V_ACT_DEF,
    parameter int SKIP_FRAMES = 10,
    parameter int SWAP_RB     = 1
) (
    input  logic                   cmos_pclk,
    input  logic                   rst_n,
    input  logic                   cmos_vsync,
    input  logic                   cmos_href,
    input  logic [7:0]             cmos_db,
    input  logic                   cap_en,
    input  logic                   err_clr,
    output logic                   vout_vs_n,
    output logic                   vout_de,
    output logic [15:0]            vout_data,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   err,
    output logic                   cap_active
);

    logic       vs_q, vs_prev;
    logic       hr_q, hr_prev;
    logic [7:0] db_q;

    always_ff @(posedge cmos_pclk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q    <= 1'b0;
            vs_prev <= 1'b0;
            hr_q    <= 1'b0;
            hr_prev <= 1'b0;
            db_q    <= '0;
        end else begin
            vs_q    <= cmos_vsync;
            vs_prev <= vs_q;
            hr_q    <= cmos_href;
            hr_prev <= hr_q;
            db_q    <= cmos_db;
        end
    end

    logic fb;
    logic line_end;

    assign fb       = vs_q & ~vs_prev;
    assign line_end = hr_prev & ~hr_q;

    cap_state_t            state, state_nxt;
    logic [SKIP_CNT_W-1:0] skip_cnt, skip_cnt_nxt;
    logic                  vs_n_nxt;

    always_comb begin
        state_nxt    = state;
        skip_cnt_nxt = skip_cnt;
        case (state)
            SKIP: begin
                if (fb) begin
                    if (skip_cnt == SKIP_CNT_W'(SKIP_FRAMES)) begin
                        state_nxt = ACTIVE;
                    end else begin
                        skip_cnt_nxt = skip_cnt + SKIP_CNT_W'(1);
                    end
                end
            end
            ACTIVE: begin
                if (fb && !cap_en) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (fb && cap_en) begin
                    state_nxt = ACTIVE;
                end
            end
            default: state_nxt = SKIP;
        endcase
        // Looking at the next state lets the frame that starts ACTIVE get
        // its sync pulse, and the first IDLE frame get none.
        vs_n_nxt = ~(vs_q & (state_nxt == ACTIVE));
    end

    always_ff @(posedge cmos_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SKIP;
            skip_cnt  <= '0;
            vout_vs_n <= 1'b1;
        end else begin
            state     <= state_nxt;
            skip_cnt  <= skip_cnt_nxt;
            vout_vs_n <= vs_n_nxt;
        end
    end

    assign cap_active = (state == ACTIVE);

    logic pair_phase;

    cmos_byte_pair #(
        .SWAP_RB (SWAP_RB != 0)
    ) u_byte_pair (
        .cmos_pclk (cmos_pclk),
        .rst_n     (rst_n),
        .en        (cap_active),
        .hr_q      (hr_q),
        .db_q      (db_q),
        .de        (vout_de),
        .data      (vout_data),
        .phase     (pair_phase)
    );

    // Counts the pixel on the same edge the pair module emits it, so the
    // count is complete by the time the href fall is seen.
    logic pix_inc;
    assign pix_inc = cap_active & hr_q & pair_phase;

    logic [CNT_W-1:0] pix_cnt;
    logic [CNT_W-1:0] line_cnt;

    always_ff @(posedge cmos_pclk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt  <= '0;
            line_cnt <= '0;
        end else if (fb) begin
            pix_cnt  <= '0;
            line_cnt <= '0;
        end else if (line_end) begin
            pix_cnt <= '0;
            if (line_cnt != '1) begin
                line_cnt <= line_cnt + CNT_W'(1);
            end
        end else if (pix_inc && (pix_cnt != '1)) begin
            pix_cnt <= pix_cnt + CNT_W'(1);
        end
    end

    logic line_bad;
    logic frame_bad;
    logic err_set;

    // An odd byte count leaves phase set at the href fall.
    assign line_bad  = line_end & ((pix_cnt != CNT_W'(H_ACT)) | pair_phase);
    assign frame_bad = fb & (line_cnt != CNT_W'(V_ACT));
    assign err_set   = cap_active & (line_bad | frame_bad);

    always_ff @(posedge cmos_pclk or negedge rst_n) begin
        if (!rst_n) begin
            err       <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (err_set) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
            if (fb && cap_active) begin
                frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cmos_frame_capture.sv
module tb_cmos_frame_capture;

    localparam int H    = 8;
    localparam int V    = 4;
    localparam int SKIP = 2;

    logic        cmos_pclk;
    logic        rst_n;
    logic        cmos_vsync;
    logic        cmos_href;
    logic [7:0]  cmos_db;
    logic        cap_en;
    logic        err_clr;

    logic        vs_n0, de0, err0, act0;
    logic [15:0] data0;
    logic [7:0]  fcnt0;
    logic        vs_n1, de1, err1, act1;
    logic [15:0] data1;
    logic [7:0]  fcnt1;

    cmos_frame_capture #(
        .H_ACT(H), .V_ACT(V), .SKIP_FRAMES(SKIP), .SWAP_RB(1)
    ) dut_swap (
        .cmos_pclk(cmos_pclk), .rst_n(rst_n), .cmos_vsync(cmos_vsync),
        .cmos_href(cmos_href), .cmos_db(cmos_db), .cap_en(cap_en),
        .err_clr(err_clr), .vout_vs_n(vs_n0), .vout_de(de0),
        .vout_data(data0), .frame_cnt(fcnt0), .err(err0), .cap_active(act0)
    );

    cmos_frame_capture #(
        .H_ACT(H), .V_ACT(V), .SKIP_FRAMES(SKIP), .SWAP_RB(0)
    ) dut_plain (
        .cmos_pclk(cmos_pclk), .rst_n(rst_n), .cmos_vsync(cmos_vsync),
        .cmos_href(cmos_href), .cmos_db(cmos_db), .cap_en(cap_en),
        .err_clr(err_clr), .vout_vs_n(vs_n1), .vout_de(de1),
        .vout_data(data1), .frame_cnt(fcnt1), .err(err1), .cap_active(act1)
    );

    initial cmos_pclk = 1'b0;
    always #5 cmos_pclk = ~cmos_pclk;

    int tests = 0;
    int fails = 0;
    int de_cnt = 0;

    always @(posedge cmos_pclk) if (de0) de_cnt <= de_cnt + 1;

    typedef struct {
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic [15:0] exp_swap;
        logic [15:0] exp_plain;
    } pix_vec_t;

    pix_vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge cmos_pclk);
        #1;
    endtask

    task automatic send_line(input int nbytes, input logic clr_at_set,
                             output logic err_pre, output logic err_post);
        for (int i = 0; i < nbytes; i++) begin
            cmos_href = 1'b1;
            cmos_db   = 8'(8'h40 + i);
            step();
        end
        cmos_href = 1'b0;
        cmos_db   = 8'h00;
        step();
        err_pre = err0;
        if (clr_at_set) err_clr = 1'b1;
        step();
        err_post = err0;
        err_clr  = 1'b0;
        step();
        step();
    endtask

    task automatic lines(input int n);
        logic a, b;
        for (int i = 0; i < n; i++) send_line(2 * H, 1'b0, a, b);
    endtask

    task automatic frame_start(output logic vs_a, output logic vs_b);
        cmos_vsync = 1'b1;
        step();
        vs_a = vs_n0;
        step();
        vs_b = vs_n0;
        step();
        cmos_vsync = 1'b0;
        step();
        step();
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
    endtask

    initial begin
        logic va, vb, e_pre, e_post;
        int base;

        vecs[0] = '{8'hF8, 8'h1F, 16'hF81F, 16'hF81F};
        vecs[1] = '{8'hF8, 8'h00, 16'h001F, 16'hF800};
        vecs[2] = '{8'h00, 8'h1F, 16'hF800, 16'h001F};
        vecs[3] = '{8'h07, 8'hE0, 16'h07E0, 16'h07E0};
        vecs[4] = '{8'h12, 8'h34, 16'hA222, 16'h1234};
        vecs[5] = '{8'hAB, 8'hCD, 16'h6BD5, 16'hABCD};
        vecs[6] = '{8'hFF, 8'hFF, 16'hFFFF, 16'hFFFF};
        vecs[7] = '{8'h00, 8'h01, 16'h0800, 16'h0001};

        rst_n = 1'b0; cmos_vsync = 1'b0; cmos_href = 1'b0; cmos_db = 8'h00;
        cap_en = 1'b1; err_clr = 1'b0;
        step(); step();
        check("rst_vs_n", vs_n0, 1);
        check("rst_de", de0, 0);
        check("rst_data", data0, 0);
        check("rst_frame_cnt", fcnt0, 0);
        check("rst_err", err0, 0);
        check("rst_cap_active", act0, 0);
        rst_n = 1'b1;
        step();

        // partial frame then two settling frames: nothing captured
        lines(2);
        frame_start(va, vb);
        check("skip1_vs_n", vb, 1);
        lines(V);
        frame_start(va, vb);
        check("skip2_active", act0, 0);
        lines(V);
        check("skip_no_de", de_cnt, 0);
        frame_start(va, vb);
        check("f3_vs_n_1cyc", va, 1);
        check("f3_vs_n_2cyc", vb, 0);
        check("f3_cap_active", act0, 1);
        check("f3_frame_cnt", fcnt0, 0);
        base = de_cnt;
        lines(V);
        check("f3_pixels", de_cnt - base, 32);
        frame_start(va, vb);
        check("f4_frame_cnt", fcnt0, 1);
        check("f4_err", err0, 0);

        // pairing table as the first line of frame 4
        for (int c = 0; c < 18; c++) begin
            if (c < 16) begin
                cmos_href = 1'b1;
                cmos_db   = (c % 2 == 0) ? vecs[c / 2].hi : vecs[c / 2].lo;
            end else begin
                cmos_href = 1'b0;
                cmos_db   = 8'h00;
            end
            step();
            if (c >= 2 && c % 2 == 0) begin
                check($sformatf("pair_de[%0d]", c / 2 - 1), de0, 1);
                check($sformatf("pair_swap[%0d]", c / 2 - 1), data0, vecs[c / 2 - 1].exp_swap);
                check($sformatf("pair_plain[%0d]", c / 2 - 1), data1, vecs[c / 2 - 1].exp_plain);
            end else if (c >= 3) begin
                check($sformatf("pair_gap_de[%0d]", c), de0, 0);
                check($sformatf("pair_hold[%0d]", c), data0, vecs[(c - 1) / 2 - 1].exp_swap);
            end
        end
        step(); step();
        check("pair_line_ok_err", err0, 0);
        lines(V - 1);

        // line length errors in frame 5
        frame_start(va, vb);
        check("f5_frame_cnt", fcnt0, 2);
        check("f5_err", err0, 0);
        send_line(14, 1'b0, e_pre, e_post);
        check("short_line_err_pre", e_pre, 0);
        check("short_line_err_post", e_post, 1);
        clear_err();
        check("err_clr", err0, 0);
        send_line(15, 1'b0, e_pre, e_post);
        check("odd_line_err_pre", e_pre, 0);
        check("odd_line_err_post", e_post, 1);
        clear_err();
        check("err_clr2", err0, 0);
        send_line(14, 1'b1, e_pre, e_post);
        check("set_vs_clr_pre", e_pre, 0);
        check("set_vs_clr_post", e_post, 1);
        check("set_vs_clr_sticky", err0, 1);
        clear_err();
        check("err_clr3", err0, 0);

        // frame 5 had only 3 lines
        frame_start(va, vb);
        check("line_count_err", err0, 1);
        check("f6_frame_cnt", fcnt0, 3);
        clear_err();

        // enable dropped mid frame 6: frame completes
        base = de_cnt;
        lines(2);
        cap_en = 1'b0;
        lines(2);
        check("en_drop_pixels", de_cnt - base, 32);
        frame_start(va, vb);
        check("f7_vs_n_a", va, 1);
        check("f7_vs_n_b", vb, 1);
        check("f7_cap_active", act0, 0);
        check("f7_frame_cnt", fcnt0, 4);
        check("f7_err", err0, 0);
        base = de_cnt;
        lines(2);
        cap_en = 1'b1;
        lines(2);
        check("idle_no_pixels", de_cnt - base, 0);
        frame_start(va, vb);
        check("f8_vs_n", vb, 0);
        check("f8_cap_active", act0, 1);
        check("f8_frame_cnt", fcnt0, 4);
        base = de_cnt;
        lines(V);
        check("f8_pixels", de_cnt - base, 32);
        frame_start(va, vb);
        check("f9_frame_cnt", fcnt0, 5);
        check("f9_err", err0, 0);

        // reset mid line
        lines(1);
        for (int i = 0; i < 5; i++) begin
            cmos_href = 1'b1;
            cmos_db   = 8'(8'h80 + i);
            step();
        end
        check("pre_rst_data_nonzero", (data0 != 16'h0000) ? 1 : 0, 1);
        rst_n = 1'b0;
        cmos_href = 1'b0;
        cmos_db = 8'h00;
        #1;
        check("mid_rst_vs_n", vs_n0, 1);
        check("mid_rst_de", de0, 0);
        check("mid_rst_data", data0, 0);
        check("mid_rst_frame_cnt", fcnt0, 0);
        check("mid_rst_err", err0, 0);
        check("mid_rst_cap_active", act0, 0);
        step(); step();
        rst_n = 1'b1;
        step();
        base = de_cnt;
        lines(2);
        frame_start(va, vb);
        check("rA_cap_active", act0, 0);
        check("rA_vs_n", vb, 1);
        lines(V);
        frame_start(va, vb);
        check("rB_cap_active", act0, 0);
        lines(V);
        check("r_skip_no_pixels", de_cnt - base, 0);
        frame_start(va, vb);
        check("rC_cap_active", act0, 1);
        check("rC_vs_n", vb, 0);
        base = de_cnt;
        lines(V);
        check("rC_pixels", de_cnt - base, 32);
        frame_start(va, vb);
        check("rD_frame_cnt", fcnt0, 1);
        check("rD_err", err0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
